// File: rtl/spi_pkg.sv
// Shared definitions for the command-driven SPI master.
// Provides the command opcode and master state encodings plus the frame
// header widths used to size the serial frame.
package spi_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    TURN  = 3'd2,
    RECV  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int CTRL_BITS = 1;
  localparam int OP_BITS   = 2;

  // Serial frame as sent on MOSI, MSB first: control bit (op[1]), opcode, payload.
  function automatic logic [CTRL_BITS+OP_BITS+7:0] build_frame8(input logic [1:0] op,
                                                               input logic [7:0] payload);
    return {op[1], op, payload};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Parallel-load, MSB-first shift register with serial in.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       load load_val_i (has priority over shift_i)
//   load_val_i   parallel load value
//   shift_i      shift left by one, sin_i enters at the LSB
//   sin_i        serial input
//   next_o       value the register takes at the next clock edge
// next_o lets the owner register a serial output (or capture a completed word)
// in the same edge that the shift happens, without an extra pipeline stage.
module spi_frame_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] next_o
);

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_val_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], sin_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign next_o = sr_d;

endmodule

// File: rtl/spi_master_drv.sv
// Command-driven SPI master. One command per valid/ready handshake is
// serialised as {op[1], op, payload} on SS_n/MOSI (one bit per clk); RD_DATA
// frames then wait TURNAROUND cycles and capture DATA_W bits from MISO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op, cmd_payload   opcode and address/data, sampled at accept
//   rsp_valid, rsp_data   1-cycle pulse with the captured read byte (data held)
//   proto_err             1-cycle pulse: RD_DATA without a preceding RD_ADDR
//   busy                  ~cmd_ready
//   SS_n, MOSI, MISO      serial interface (SS_n and MOSI registered)
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// SHIFT | sending the DATA_W+3 frame bits on MOSI
// TURN  | RD_DATA only: TURNAROUND idle cycles before the reply
// RECV  | RD_DATA only: sampling DATA_W bits of MISO
// GAP   | SS_n high for GAP_CYCLES; read result presented on entry
module spi_master_drv
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TURNAROUND = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_payload,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              proto_err,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FRAME_W = CTRL_BITS + OP_BITS + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic                ss_n_q, ss_n_d;
  logic                mosi_q, mosi_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                proto_err_q, proto_err_d;
  logic                seen_q, seen_d;

  logic                tx_load;
  logic [FRAME_W-1:0]  tx_next;
  logic [DATA_W-1:0]   rx_next;
  logic                unused_tx;

  spi_frame_shifter #(.W(FRAME_W)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tx_load),
    .load_val_i ({cmd_op[1], cmd_op, cmd_payload}),
    .shift_i    (state_q == SHIFT),
    .sin_i      (1'b0),
    .next_o     (tx_next)
  );

  spi_frame_shifter #(.W(DATA_W)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (state_q == RECV),
    .sin_i      (MISO),
    .next_o     (rx_next)
  );

  // Only the bit about to appear on MOSI is needed from the TX shifter.
  assign unused_tx = ^tx_next[FRAME_W-2:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ss_n_d      = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    proto_err_d = 1'b0;
    seen_d      = seen_q;
    tx_load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tx_load     = 1'b1;
          op_d        = cmd_op;
          state_d     = SHIFT;
          cnt_d       = SHIFT_LAST;
          ss_n_d      = 1'b0;
          proto_err_d = (cmd_op == RD_DATA) && !seen_q;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (op_q == RD_DATA) begin
            state_d = TURN;
            cnt_d   = TURN_LAST;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LAST;
            ss_n_d  = 1'b1;
            if (op_q == RD_ADDR) begin
              seen_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = RECV;
          cnt_d   = RECV_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECV: begin
        if (cnt_q == '0) begin
          // rx_next already contains the MISO bit sampled at this edge.
          state_d     = GAP;
          cnt_d       = GAP_LAST;
          ss_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_next;
          seen_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
      end
    endcase
    mosi_d = (state_d == SHIFT) ? tx_next[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      proto_err_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      proto_err_q <= proto_err_d;
      seen_q      <= seen_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign proto_err = proto_err_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master_drv.sv
module tb_spi_master_drv;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       cmd_valid;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_payload;
  logic [1:0]       cmd_ready, rsp_valid, proto_err, busy, ss_n, mosi, miso;
  logic [1:0][7:0]  rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the slave+RAM wrapper, one per DUT instance.
  logic [7:0] mem_m  [2][256];
  logic [7:0] addr_m [2];
  bit         seen_m [2];
  logic [7:0] exp_q  [$];

  always #5 clk = ~clk;

  // Instance 0: default TURNAROUND=2, instance 1: TURNAROUND=3.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int TA = (g == 0) ? 2 : 3;

    spi_master_drv #(.DATA_W(8), .TURNAROUND(TA), .GAP_CYCLES(1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid[g]),
      .cmd_ready   (cmd_ready[g]),
      .cmd_op      (cmd_op),
      .cmd_payload (cmd_payload),
      .rsp_valid   (rsp_valid[g]),
      .rsp_data    (rsp_data[g]),
      .proto_err   (proto_err[g]),
      .busy        (busy[g]),
      .SS_n        (ss_n[g]),
      .MOSI        (mosi[g]),
      .MISO        (miso[g])
    );

    // Behavioural slave + RAM: samples MOSI at posedge, drives MISO at negedge.
    int         idx;
    logic [9:0] sh;
    logic [7:0] s_addr, s_rdb;
    logic [7:0] s_mem [256];
    logic       s_miso;
    logic [7:0] pl;

    assign pl      = {sh[6:0], mosi[g]};
    assign miso[g] = s_miso;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        idx    <= 0;
        sh     <= '0;
        s_addr <= '0;
        s_rdb  <= '0;
        for (int i = 0; i < 256; i++) s_mem[i] <= 8'h00;
      end else if (ss_n[g]) begin
        idx <= 0;
      end else begin
        idx <= idx + 1;
        if (idx < 10) sh <= {sh[8:0], mosi[g]};
        if (idx == 10) begin
          case (sh[8:7])
            2'b00:   s_addr <= pl;
            2'b01:   s_mem[s_addr] <= pl;
            2'b10:   s_addr <= pl;
            default: s_rdb <= s_mem[s_addr];
          endcase
        end
      end
    end

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) s_miso <= 1'b0;
      else if (!ss_n[g] && idx >= 11 + TA && idx < 19 + TA) s_miso <= s_rdb[3'(18 + TA - idx)];
      else s_miso <= 1'b0;
    end
  end

  function automatic logic [10:0] frame_of(input logic [1:0] op, input logic [7:0] pl);
    return {op[1], op, pl};
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      addr_m[g] = 8'h00;
      seen_m[g] = 1'b0;
      for (int i = 0; i < 256; i++) mem_m[g][i] = 8'h00;
    end
    exp_q.delete();
  endtask

  // Issues one command on instance g and observes the whole frame.
  // lowc is -1 when a bound expires.
  task automatic run_frame(input int g, input logic [1:0] op, input logic [7:0] pl,
                           output int lowc, output int rspc, output logic [7:0] got,
                           output logic [7:0] expd, output int perr, output bit exp_perr,
                           output logic [10:0] tx, output bit rise_ok);
    int   n;
    logic prev_ss;
    exp_q.delete();
    exp_perr = (op == 2'b11) && !seen_m[g];
    case (op)
      2'b00:   addr_m[g] = pl;
      2'b01:   mem_m[g][addr_m[g]] = pl;
      2'b10:   addr_m[g] = pl;
      default: exp_q.push_back(mem_m[g][addr_m[g]]);
    endcase
    if (op == 2'b10) seen_m[g] = 1'b1;
    if (op == 2'b11) seen_m[g] = 1'b0;
    got = 8'h00; expd = 8'h00; lowc = 0; rspc = 0; perr = 0; tx = '0; rise_ok = 1'b0;
    cmd_op = op; cmd_payload = pl; cmd_valid[g] = 1'b1;
    n = 0;
    while (!cmd_ready[g] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid[g] = 1'b0;
    prev_ss = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!ss_n[g]) begin
        if (lowc < 11) tx = {tx[9:0], mosi[g]};
        lowc++;
      end
      if (rsp_valid[g]) begin
        rspc++;
        got = rsp_data[g];
        rise_ok = ss_n[g] && !prev_ss;
        if (exp_q.size() > 0) expd = exp_q.pop_front();
      end
      if (proto_err[g]) perr++;
      prev_ss = ss_n[g];
    end while (!cmd_ready[g] && n < 200);
    if (n >= 200) lowc = -1;
  endtask

  task automatic test_reset();
    n_checks++; if (ss_n[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ss_n: got %b want 1", ss_n[0]); end
    n_checks++; if (mosi[0] !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi[0]); end
    n_checks++; if (cmd_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", cmd_ready); end
    n_checks++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b want 00", busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_data[0] !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data[0]); end
    n_checks++; if (proto_err !== 2'b00) begin n_fail++; $display("FAIL reset_proto_err: got %b want 00", proto_err); end
  endtask

  task automatic test_rd_after_reset();
    int lowc, rspc, perr; logic [7:0] got, expd; bit ep, rise; logic [10:0] tx;
    run_frame(0, 2'b11, 8'h77, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (lowc !== 21) begin n_fail++; $display("FAIL rd0_low_cycles: got %0d want 21", lowc); end
    n_checks++; if (perr !== 1 || !ep) begin n_fail++; $display("FAIL rd0_proto_err: got %0d pulses want 1", perr); end
    n_checks++; if (rspc !== 1) begin n_fail++; $display("FAIL rd0_rsp_count: got %0d want 1", rspc); end
    n_checks++; if (got !== 8'h00) begin n_fail++; $display("FAIL rd0_rsp_data: got %h want 00", got); end
  endtask

  task automatic test_wr_addr();
    int lowc, rspc, perr; logic [7:0] got, expd; bit ep, rise; logic [10:0] tx;
    run_frame(0, 2'b00, 8'hA5, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (lowc !== 11) begin n_fail++; $display("FAIL wr_addr_low_cycles: got %0d want 11", lowc); end
    n_checks++; if (tx !== 11'b000_1010_0101) begin n_fail++; $display("FAIL wr_addr_mosi: got %b want 00010100101", tx); end
    n_checks++; if (rspc !== 0 || perr !== 0) begin n_fail++; $display("FAIL wr_addr_no_rsp: got rsp %0d perr %0d want 0 0", rspc, perr); end
  endtask

  task automatic test_read_path();
    int lowc, rspc, perr; logic [7:0] got, expd; bit ep, rise; logic [10:0] tx;
    run_frame(0, 2'b01, 8'h3C, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (tx !== frame_of(2'b01, 8'h3C) || lowc !== 11) begin n_fail++; $display("FAIL wr_data_frame: got %b/%0d want %b/11", tx, lowc, frame_of(2'b01, 8'h3C)); end
    run_frame(0, 2'b10, 8'hA5, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (tx !== frame_of(2'b10, 8'hA5) || lowc !== 11) begin n_fail++; $display("FAIL rd_addr_frame: got %b/%0d want %b/11", tx, lowc, frame_of(2'b10, 8'hA5)); end
    run_frame(0, 2'b11, 8'h00, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (lowc !== 21) begin n_fail++; $display("FAIL rd_data_low_cycles: got %0d want 21", lowc); end
    n_checks++; if (tx !== frame_of(2'b11, 8'h00)) begin n_fail++; $display("FAIL rd_data_mosi: got %b want %b", tx, frame_of(2'b11, 8'h00)); end
    n_checks++; if (rspc !== 1) begin n_fail++; $display("FAIL rd_data_rsp_count: got %0d want 1", rspc); end
    n_checks++; if (got !== 8'h3C || got !== expd) begin n_fail++; $display("FAIL rd_data_value: got %h want 3c (model %h)", got, expd); end
    n_checks++; if (!rise) begin n_fail++; $display("FAIL rd_data_rsp_timing: got rsp_valid not aligned with SS_n rise want aligned"); end
    n_checks++; if (perr !== 0) begin n_fail++; $display("FAIL rd_data_no_proto: got %0d pulses want 0", perr); end
    n_checks++; if (rsp_data[0] !== 8'h3C) begin n_fail++; $display("FAIL rsp_data_hold: got %h want 3c", rsp_data[0]); end
    run_frame(0, 2'b11, 8'h00, lowc, rspc, got, expd, perr, ep, tx, rise);
    n_checks++; if (perr !== 1 || !ep) begin n_fail++; $display("FAIL rd_data_repeat_proto: got %0d pulses want 1", perr); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] tx1, tx2; int low1, low2, high, n;
    tx1 = '0; tx2 = '0; low1 = 0; low2 = 0; high = 0;
    cmd_op = 2'b00; cmd_payload = 8'hC3; cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    n = 0;
    // Frame 1 while the command inputs keep changing underneath it.
    do begin
      @(negedge clk); n++;
      if (!ss_n[0]) begin tx1 = {tx1[9:0], mosi[0]}; low1++; end
      cmd_op = 2'($urandom); cmd_payload = 8'($urandom);
    end while (!ss_n[0] && n < 100);
    high = 1;
    n = 0;
    while (n < 100) begin
      if (cmd_ready[0]) begin cmd_op = 2'b00; cmd_payload = 8'h5A; end
      @(negedge clk); n++;
      if (!ss_n[0]) break;
      high++;
      if (!cmd_ready[0]) begin cmd_op = 2'($urandom); cmd_payload = 8'($urandom); end
    end
    cmd_valid[0] = 1'b0;
    n = 0;
    while (!ss_n[0] && n < 100) begin
      tx2 = {tx2[9:0], mosi[0]}; low2++;
      @(negedge clk); n++;
    end
    n = 0;
    while (!cmd_ready[0] && n < 100) begin @(negedge clk); n++; end
    addr_m[0] = 8'h5A;
    n_checks++; if (tx1 !== frame_of(2'b00, 8'hC3) || low1 !== 11) begin n_fail++; $display("FAIL b2b_frame1: got %b/%0d want %b/11", tx1, low1, frame_of(2'b00, 8'hC3)); end
    n_checks++; if (high < 1 || high > 2) begin n_fail++; $display("FAIL b2b_gap: got %0d high cycles want 1..2", high); end
    n_checks++; if (tx2 !== frame_of(2'b00, 8'h5A) || low2 !== 11) begin n_fail++; $display("FAIL b2b_frame2: got %b/%0d want %b/11", tx2, low2, frame_of(2'b00, 8'h5A)); end
  endtask

  task automatic test_reset_mid_frame();
    int n, lows, rsps;
    cmd_op = 2'b01; cmd_payload = 8'hFF; cmd_valid[0] = 1'b1;
    n = 0;
    while (!cmd_ready[0] && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    n_checks++; if (ss_n[0] !== 1'b0 || mosi[0] !== 1'b1) begin n_fail++; $display("FAIL mid_frame_bit5: got ss %b mosi %b want 0 1", ss_n[0], mosi[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ss_n[0] !== 1'b1 || mosi[0] !== 1'b0) begin n_fail++; $display("FAIL async_abort: got ss %b mosi %b want 1 0", ss_n[0], mosi[0]); end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    lows = 0; rsps = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!ss_n[0]) lows++;
      if (rsp_valid[0]) rsps++;
    end
    n_checks++; if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", cmd_ready[0]); end
    n_checks++; if (lows !== 0 || rsps !== 0) begin n_fail++; $display("FAIL abort_quiet: got low %0d rsp %0d want 0 0", lows, rsps); end
  endtask

  task automatic test_random();
    int lowc, rspc, perr, want_low; logic [7:0] got, expd, pl; bit ep, rise; logic [10:0] tx; logic [1:0] op;
    for (int k = 0; k < 200; k++) begin
      op = 2'($urandom_range(0, 3));
      pl = (op == 2'b01) ? 8'($urandom) : 8'($urandom_range(0, 7));
      run_frame(1, op, pl, lowc, rspc, got, expd, perr, ep, tx, rise);
      want_low = (op == 2'b11) ? 22 : 11;
      n_checks++; if (lowc !== want_low) begin n_fail++; $display("FAIL rnd%0d_low_cycles: got %0d want %0d", k, lowc, want_low); end
      n_checks++; if (tx !== frame_of(op, pl)) begin n_fail++; $display("FAIL rnd%0d_mosi: got %b want %b", k, tx, frame_of(op, pl)); end
      n_checks++; if (perr !== int'(ep)) begin n_fail++; $display("FAIL rnd%0d_proto_err: got %0d want %0d", k, perr, ep); end
      n_checks++; if (rspc !== int'(op == 2'b11)) begin n_fail++; $display("FAIL rnd%0d_rsp_count: got %0d want %0d", k, rspc, op == 2'b11); end
      if (op == 2'b11) begin
        n_checks++; if (got !== expd || !rise) begin n_fail++; $display("FAIL rnd%0d_rsp_data: got %h (aligned %b) want %h", k, got, rise, expd); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 2'b00; cmd_op = 2'b00; cmd_payload = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_rd_after_reset();
    test_wr_addr();
    test_read_path();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
